// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: control FSM for a repeated-addition multiplier datapath.
// It takes operand A, then operand B, over a shared valid/ready bus, and
// drives the datapath strobes until B reaches zero. It then holds done
// until the master acknowledges the result.
// Optional build macro MUL_CTRL_TIMEOUT_EN enables an iteration watchdog.
// When the watchdog fires, the FSM finishes early and reports err.
module mul_seq_ctrl #(
  parameter int WIDTH    = 16,
  parameter int MAX_ITER = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic             eqz,
  output logic             ldA,
  output logic             ldB,
  output logic             ldP,
  output logic             clrP,
  output logic             decB,
  output logic             busy,
  output logic             done,
  input  logic             done_ack,
  output logic             err,
  output logic [WIDTH-1:0] iter_cnt
);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, ADD, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] iter_nxt;
  logic             err_q, err_nxt;
  logic             timeout;

`ifdef MUL_CTRL_TIMEOUT_EN
  // Watchdog trips when the iteration budget is used up but B is still non-zero.
  assign timeout = (state == ADD) && !eqz && (iter_cnt == WIDTH'(MAX_ITER));
`else
  // Without the watchdog the limit parameter has no function.
  logic unused_max_iter;
  assign unused_max_iter = (MAX_ITER == 0);
  assign timeout         = 1'b0;
`endif

  assign err = err_q;

  // State, iteration count and error flag registers (synchronous reset).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      iter_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      iter_cnt <= iter_nxt;
      err_q    <= err_nxt;
    end
  end

  // Next-state logic and strobe decode.
  // Abort takes precedence over op_valid and eqz.
  // All outputs are gated low while reset is held.
  always_comb begin
    state_nxt = state;
    iter_nxt  = iter_cnt;
    err_nxt   = err_q;
    op_ready  = 1'b0;
    ldA       = 1'b0;
    ldB       = 1'b0;
    ldP       = 1'b0;
    clrP      = 1'b0;
    decB      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD_A;
          iter_nxt  = '0;
        end
      end
      LOAD_A: begin
        busy = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          op_ready = 1'b1;
          ldA      = op_valid;
          if (op_valid) state_nxt = LOAD_B;
        end
      end
      LOAD_B: begin
        busy = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          op_ready = 1'b1;
          ldB      = op_valid;
          clrP     = op_valid;
          if (op_valid) state_nxt = ADD;
        end
      end
      ADD: begin
        busy = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (eqz) begin
          state_nxt = DONE;
        end else if (timeout) begin
          state_nxt = DONE;
          err_nxt   = 1'b1;
        end else begin
          ldP  = 1'b1;
          decB = 1'b1;
          // Saturate the count at all-ones instead of wrapping.
          if (iter_cnt != '1) iter_nxt = iter_cnt + 1'b1;
        end
      end
      DONE: begin
        done = 1'b1;
        if (done_ack) begin
          state_nxt = IDLE;
          err_nxt   = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!rst_n) begin
      op_ready = 1'b0;
      ldA      = 1'b0;
      ldB      = 1'b0;
      ldP      = 1'b0;
      clrP     = 1'b0;
      decB     = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl. It contains a behavioural datapath (A, B counter,
// P accumulator) driven by the DUT strobes. Expected results come from
// plain arithmetic: P = A*min(B,limit), ADD cycles = iterations+1.
module tb_mul_seq_ctrl;
`ifdef MUL_CTRL_TIMEOUT_EN
  localparam int MI    = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int MI    = 65535;
  localparam bit TO_EN = 1'b0;
`endif
  localparam int W = 16;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         start = 1'b0, abort = 1'b0, op_valid = 1'b0, done_ack = 1'b0;
  logic [W-1:0] bus = '0;
  logic         op_ready, ldA, ldB, ldP, clrP, decB, busy, done, err, eqz;
  logic [W-1:0] iter_cnt;

  logic [W-1:0] a_reg = '0, b_reg = '0;
  logic [31:0]  p_reg = '0;

  int checks = 0, errors = 0;
  int n_ldA = 0, n_ldB = 0, n_ldP = 0, n_clrP = 0, n_decB = 0, n_done = 0, n_bad = 0;

  mul_seq_ctrl #(.WIDTH(W), .MAX_ITER(MI)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .op_valid(op_valid), .op_ready(op_ready), .eqz(eqz),
    .ldA(ldA), .ldB(ldB), .ldP(ldP), .clrP(clrP), .decB(decB),
    .busy(busy), .done(done), .done_ack(done_ack), .err(err), .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  assign eqz = (b_reg == '0);

  // Behavioural datapath.
  always @(posedge clk) begin
    if (ldA) a_reg <= bus;
    if (ldB) b_reg <= bus;
    else if (decB) b_reg <= b_reg - 1'b1;
    if (clrP) p_reg <= '0;
    else if (ldP) p_reg <= p_reg + 32'(a_reg);
  end

  // Strobe pulse counters and exclusivity monitor.
  always @(posedge clk) begin
    n_ldA  <= n_ldA + int'(ldA);
    n_ldB  <= n_ldB + int'(ldB);
    n_ldP  <= n_ldP + int'(ldP);
    n_clrP <= n_clrP + int'(clrP);
    n_decB <= n_decB + int'(decB);
    n_done <= n_done + int'(done);
    if ((int'(ldA) + int'(ldB) + int'(ldP)) > 1 || (clrP && !ldB) || (ldP != decB))
      n_bad <= n_bad + 1;
  end

  function automatic logic [7:0] outs();
    return {op_ready, ldA, ldB, ldP, clrP, decB, busy, done};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete multiply with optional stalls on each operand beat.
  task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b, input int sa, input int sb);
    int eff_b, n, k, b0_ldA, b0_ldB, b0_ldP, b0_clrP, b0_decB;
    bit to;
    to    = TO_EN && (int'(b) > MI);
    eff_b = to ? MI : int'(b);
    start = 1'b1;
    #1 check("idle_quiet", 32'(outs()), 32'h0);
    @(negedge clk);
    start   = 1'b0;
    b0_ldA  = n_ldA;  b0_ldB = n_ldB; b0_ldP = n_ldP;
    b0_clrP = n_clrP; b0_decB = n_decB;
    for (int i = 0; i < sa; i++) begin
      op_valid = 1'b0; bus = W'($urandom);
      #1 check("stallA", 32'({op_ready, ldA, busy}), 32'b101);
      @(negedge clk);
    end
    op_valid = 1'b1; bus = a; start = 1'b1;
    #1 check("beatA", 32'({op_ready, ldA, ldB, busy}), 32'b1101);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < sb; i++) begin
      op_valid = 1'b0; bus = W'($urandom);
      #1 check("stallB", 32'({op_ready, ldB, clrP, busy}), 32'b1001);
      @(negedge clk);
    end
    op_valid = 1'b1; bus = b;
    #1 check("beatB", 32'({op_ready, ldA, ldB, clrP}), 32'b1011);
    @(negedge clk);
    op_valid = 1'b0; bus = W'($urandom);
    n = 0;
    while (!done && n < 300) begin
      n++;
      @(negedge clk);
    end
    check("add_cycles", 32'(n), 32'(eff_b + 1));
    check("done_state", 32'({done, busy}), 32'b10);
    check("iter_cnt", 32'(iter_cnt), 32'(eff_b));
    check("err", 32'(err), 32'(to));
    check("product", p_reg, 32'(a) * 32'(eff_b));
    check("pulses", {8'(n_ldA - b0_ldA), 8'(n_ldB - b0_ldB), 8'(n_clrP - b0_clrP), 8'(n_decB - b0_decB)},
          {8'd1, 8'd1, 8'd1, 8'(eff_b)});
    check("ldP_pulses", 32'(n_ldP - b0_ldP), 32'(eff_b));
    // done must hold while unacknowledged; abort/start here are ignored.
    k = $urandom_range(0, 3);
    for (int i = 0; i < k; i++) begin
      abort = 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1));
      #1 check("done_hold", 32'({done, err, iter_cnt}), 32'({1'b1, to, W'(eff_b)}));
      @(negedge clk);
    end
    abort = 1'b0; start = 1'b0; done_ack = 1'b1;
    #1 check("ack_cycle", 32'(done), 32'd1);
    @(negedge clk);
    done_ack = 1'b0;
    #1 check("after_ack", 32'({outs(), err}), 32'h0);
    @(negedge clk);
  endtask

  initial begin
    int d0;
    // Reset held with active inputs: everything quiet.
    rst_n = 1'b0; start = 1'b1; op_valid = 1'b1;
    #1 check("rst_held_outs", 32'(outs()), 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("rst_outs", 32'({outs(), err}), 32'h0);
    check("rst_iter", 32'(iter_cnt), 32'h0);
    rst_n = 1'b1; start = 1'b0; op_valid = 1'b0;
    @(negedge clk);
    check("idle_after_rst", 32'(outs()), 32'h0);

    // Basic and zero-multiplier cases.
    do_mul(16'd5, 16'd3, 0, 0);
    do_mul(16'd7, 16'd0, 0, 0);

    // Stalled versus unstalled transfers of the same operands.
    do_mul(16'd9, 16'd6, 4, 2);
    do_mul(16'd9, 16'd6, 0, 0);

    // Abort in LOAD_A: abort wins over op_valid.
    start = 1'b1; @(negedge clk); start = 1'b0;
    abort = 1'b1; op_valid = 1'b1; bus = 16'd1;
    #1 check("abortA_strobes", 32'({op_ready, ldA, busy}), 32'b001);
    @(negedge clk);
    abort = 1'b0; op_valid = 1'b0;
    #1 check("abortA_idle", 32'(outs()), 32'h0);
    @(negedge clk);

    // Abort in the second ADD cycle with B = 10.
    d0 = n_done;
    start = 1'b1; @(negedge clk); start = 1'b0;
    op_valid = 1'b1; bus = 16'd11; @(negedge clk);
    bus = 16'd10; @(negedge clk);
    op_valid = 1'b0;
    #1 check("add1_ldP", 32'({ldP, decB, busy}), 32'b111);
    @(negedge clk);
    abort = 1'b1;
    #1 check("abort_add", 32'({op_ready, ldA, ldB, ldP, clrP, decB, busy}), 32'b0000001);
    @(negedge clk);
    abort = 1'b0;
    #1 check("abort_idle", 32'(outs()), 32'h0);
    check("abort_iter_hold", 32'(iter_cnt), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("abort_no_done", 32'(n_done - d0), 32'd0);
    do_mul(16'd2, 16'd4, 0, 0);

    // Reset during LOAD_B.
    start = 1'b1; @(negedge clk); start = 1'b0;
    op_valid = 1'b1; bus = 16'd3; @(negedge clk);
    rst_n = 1'b0; bus = 16'd4;
    #1 check("rst_midop_held", 32'(outs()), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; op_valid = 1'b0;
    #1 check("rst_midop_idle", 32'({outs(), err}), 32'h0);
    @(negedge clk);
    check("rst_midop_stays", 32'(outs()), 32'h0);

    // Trips the watchdog when it is built in; an ordinary multiply otherwise.
    do_mul(16'd3, 16'd10, 0, 0);

    // Randomised operands and stalls.
    for (int r = 0; r < 10; r++)
      do_mul(W'($urandom_range(0, 1000)), W'($urandom_range(0, 12)),
             $urandom_range(0, 3), $urandom_range(0, 3));

    check("strobe_exclusive", 32'(n_bad), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
